dmem_responder: RTL and testbench
=================================

# dmem_responder

Data-memory responder on the far end of the CPU's load/store port: it accepts `load_en`/`l_addr` reads and `store_en`/`s_addr`/`s_data` writes and returns `l_data`. Stores are posted into a small write buffer that drains to an arbitrated synchronous SRAM port. Loads go to SRAM or are forwarded from the buffer. `busy` back-pressures the pipeline's stall input.

## Interface
- `W`, `WORD_WIDTH`: data and address width.
- `WB_DEPTH`, 4: write-buffer entries; power of two, minimum 2.
- `clk` input 1: single clock, rising edge.
- `rst` input 1: asynchronous, active-low reset.
- `load_en` input 1: load request, held by the CPU while `busy`.
- `l_addr` input W: load byte address; bits [1:0] ignored.
- `l_data` output W: load word, registered.
- `store_en` input 1: store request, held by the CPU while `busy`.
- `s_addr` input W: store byte address; bits [1:0] ignored.
- `s_data` input W: store word, already lane-aligned by the CPU.
- `busy` output 1: request not accepted this cycle.
- `sram_req` output 1: SRAM access request.
- `sram_we` output 1: 1 = write, 0 = read.
- `sram_addr` output W-2: word address.
- `sram_wdata` output W: write data.
- `sram_rdata` input W: read data, valid the cycle after a granted read.
- `sram_gnt` input 1: arbiter grant for the current request.

## Operation
- The buffer is a circular FIFO with head/tail pointers of width log2(WB_DEPTH), wrapping modulo depth, and a count of width log2(WB_DEPTH)+1.
- Store accept: `store_en` and count < WB_DEPTH, using registered count only. A pop in the same cycle does not free a slot for that cycle's push.
- Store full: `store_en` with count == WB_DEPTH gives `busy`=1 and no enqueue.
- Load lookup: compare `l_addr[W-1:2]` against all valid entries; the newest matching entry wins.
- A load sees only entries present at the start of the cycle. A same-cycle store is ordered after the load.
- Load hit (forwarding compiled in): no SRAM access. The matched data is registered into `l_data`.
- Load miss: `sram_req`=1, `sram_we`=0, `sram_addr`=`l_addr[W-1:2]`.
  - `sram_gnt`=1: capture the read.
  - `sram_gnt`=0: `busy`=1 and the load is retried next cycle.
- Drain: when the buffer is non-empty and no load is using the SRAM port this cycle, `sram_req`=1, `sram_we`=1 with the head entry's address and data. The head pops on `sram_gnt`.
- Loads take priority over drain.
- FSM for the load path:
  - IDLE → RESP on a granted SRAM read; IDLE stays IDLE on a forward hit.
  - RESP: `l_data` <= `sram_rdata`, then go to IDLE. A new `load_en` in RESP is processed as in IDLE (back-to-back loads allowed).
- `busy` is combinational: full+store, or ungranted load, or forwarding-disabled conflict (see Configuration).
- Reset mid-drain: all entries are discarded and the in-flight SRAM write is abandoned. The SRAM side must tolerate a dropped request.

## Timing
- Reset values: `l_data`=0, count=0, pointers=0, FSM=IDLE, `sram_req`=0, `busy`=0.
- Load latency is 1 cycle for both forward and SRAM: the request is in cycle N and `l_data` is valid from N+1.
- `l_data` holds its value until the next completed load.
- A store enters the buffer at the edge ending its accept cycle. It is forwardable from the next cycle and drains no earlier than the next cycle.
- A non-full buffer with continuous grant drains 1 entry per cycle.
- `sram_req`, `sram_we`, `sram_addr` and `sram_wdata` are combinational from the state and the CPU request.

## Configuration
- `DMEM_FWD_EN` defined: store-to-load forwarding as above.
- `DMEM_FWD_EN` undefined:
  - A load matching any valid entry asserts `busy` and makes no SRAM read.
  - Drain proceeds even while such a load is pending.
  - The load completes once no matching entry remains.
  - No data comparator mux is built.

## Structure
- Use the existing `defines.v` for `WORD_WIDTH`, `TRUE`/`FALSE`.
- Add `DMEM_IDLE`/`DMEM_RESP` state encodings and the `WB_DEPTH` default there.
- Sub-module `store_buffer`:
  - FIFO storage, pointers and count.
  - Push/pop ports and full/empty flags.
  - Combinational newest-match lookup (hit, data).
- `dmem_responder` owns the load FSM, SRAM arbitration and `busy`.

## Test plan
- Reset, then load 0x100 with SRAM word 0x40 = 0xDEADBEEF and gnt=1 → `l_data`=0xDEADBEEF in cycle N+1, `busy` never set.
- Store 0x200←0x11111111, then store 0x200←0x22222222 with gnt=0, then load 0x200 → forwarded `l_data`=0x22222222 and no `sram_req` with `sram_we`=0. With `DMEM_FWD_EN` undefined: `busy`=1 until gnt is raised and both entries drain, then `l_data`=0x22222222.
- 5 stores with gnt=0 → stores 1–4 accepted; store 5 sees `busy`=1. Raise gnt → head pops and store 5 is accepted the cycle after the pop, not the same cycle.
- Load miss with gnt=0 for 3 cycles, then 1 → `busy`=1 for 3 cycles, `l_data` updates exactly once.
- Buffer holds 3 entries and a load miss arrives with gnt=1 → the load wins the port that cycle, drain resumes next cycle. After 3 further granted cycles the buffer is empty and the SRAM holds the values in FIFO order.
- Deassert `rst` mid-drain with 2 entries → all outputs at reset values immediately. After release, a load of a previously buffered address returns the SRAM contents, not buffer data.

Source files
------------

// File: rtl/dmem_responder_pkg.sv
// Shared constants and types for the data-memory responder.
// Optional feature macro used by the design: DMEM_FWD_EN (store-to-load forwarding).
package dmem_responder_pkg;

  localparam int unsigned WORD_WIDTH       = 32;
  localparam int unsigned WB_DEPTH_DEFAULT = 4;

  localparam logic TRUE  = 1'b1;
  localparam logic FALSE = 1'b0;

  // Load-path FSM: RESP is the cycle in which SRAM read data is returned.
  typedef enum logic {
    DMEM_IDLE = 1'b0,
    DMEM_RESP = 1'b1
  } dmem_state_e;

endpackage

// File: rtl/dmem_responder_if.sv
// CPU load/store port plus arbitrated SRAM port of the data-memory responder.
// The slave modport is the responder's view; master is the surrounding system.
interface dmem_responder_if
  import dmem_responder_pkg::*;
#(
  parameter int unsigned W = WORD_WIDTH
);

  logic         load_en;
  logic [W-1:0] l_addr;
  logic [W-1:0] l_data;
  logic         store_en;
  logic [W-1:0] s_addr;
  logic [W-1:0] s_data;
  logic         busy;
  logic         sram_req;
  logic         sram_we;
  logic [W-3:0] sram_addr;
  logic [W-1:0] sram_wdata;
  logic [W-1:0] sram_rdata;
  logic         sram_gnt;

  modport slave (
    input  load_en, l_addr, store_en, s_addr, s_data, sram_rdata, sram_gnt,
    output l_data, busy, sram_req, sram_we, sram_addr, sram_wdata
  );

  modport master (
    output load_en, l_addr, store_en, s_addr, s_data, sram_rdata, sram_gnt,
    input  l_data, busy, sram_req, sram_we, sram_addr, sram_wdata
  );

endinterface

// File: rtl/dmem_responder_store_buffer.sv
// Posted-store write buffer: circular FIFO with newest-match address lookup.
// With DMEM_FWD_EN defined the lookup also returns the matching data word;
// otherwise only the hit flag is built.
module dmem_responder_store_buffer
  import dmem_responder_pkg::*;
#(
  parameter int unsigned W        = WORD_WIDTH,
  parameter int unsigned WB_DEPTH = WB_DEPTH_DEFAULT
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-3:0] push_addr,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic         full,
  output logic         empty,
  output logic [W-3:0] head_addr,
  output logic [W-1:0] head_data,
  input  logic [W-3:0] lookup_addr,
  output logic         hit
`ifdef DMEM_FWD_EN
  ,
  output logic [W-1:0] hit_data
`endif
);

  localparam int unsigned PtrW = $clog2(WB_DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  logic [W-3:0]    addr_q [WB_DEPTH];
  logic [W-1:0]    data_q [WB_DEPTH];
  logic [PtrW-1:0] head_q, tail_q;
  logic [CntW-1:0] count_q;

  // Entry storage needs no reset: validity is carried by count alone.
  always_ff @(posedge clk) begin
    if (push) begin
      addr_q[tail_q] <= push_addr;
      data_q[tail_q] <= push_data;
    end
  end

  // Pointers wrap naturally because the depth is a power of two.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      if (push) tail_q <= tail_q + 1'b1;
      if (pop)  head_q <= head_q + 1'b1;
      if (push && !pop)      count_q <= count_q + 1'b1;
      else if (pop && !push) count_q <= count_q - 1'b1;
    end
  end

  assign full      = (count_q == CntW'(WB_DEPTH));
  assign empty     = (count_q == '0);
  assign head_addr = addr_q[head_q];
  assign head_data = data_q[head_q];

  // Scan oldest to newest so the last valid match (the newest store) wins.
  always_comb begin
    hit = 1'b0;
`ifdef DMEM_FWD_EN
    hit_data = '0;
`endif
    for (int unsigned i = 0; i < WB_DEPTH; i++) begin
      if ((CntW'(i) < count_q) && (addr_q[head_q + PtrW'(i)] == lookup_addr)) begin
        hit = 1'b1;
`ifdef DMEM_FWD_EN
        hit_data = data_q[head_q + PtrW'(i)];
`endif
      end
    end
  end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: posts stores into a write buffer that drains to the
// arbitrated SRAM port, serves loads from SRAM or by forwarding from the buffer.
// Optional feature macro: DMEM_FWD_EN. Undefined, a load that matches a buffered
// store stalls until that store has drained.
module dmem_responder
  import dmem_responder_pkg::*;
#(
  parameter int unsigned W        = WORD_WIDTH,
  parameter int unsigned WB_DEPTH = WB_DEPTH_DEFAULT
) (
  input logic            clk,
  input logic            rst,
  dmem_responder_if.slave bus
);

  dmem_state_e  state_q, state_d;
  logic [W-1:0] l_data_q, l_data_d;

  logic         full, empty, hit, push, pop;
  logic [W-3:0] head_addr;
  logic [W-1:0] head_data;
  logic         store_stall, load_act, load_rd, load_blocked, fwd_conflict;
`ifdef DMEM_FWD_EN
  logic [W-1:0] hit_data;
  logic         load_fwd;
`endif

  logic unused_addr_bits;
  assign unused_addr_bits = ^{bus.l_addr[1:0], bus.s_addr[1:0]};

  dmem_responder_store_buffer #(
    .W        (W),
    .WB_DEPTH (WB_DEPTH)
  ) u_store_buffer (
    .clk         (clk),
    .rst         (rst),
    .push        (push),
    .push_addr   (bus.s_addr[W-1:2]),
    .push_data   (bus.s_data),
    .pop         (pop),
    .full        (full),
    .empty       (empty),
    .head_addr   (head_addr),
    .head_data   (head_data),
    .lookup_addr (bus.l_addr[W-1:2]),
    .hit         (hit)
`ifdef DMEM_FWD_EN
    ,
    .hit_data    (hit_data)
`endif
  );

  // A load is held back while the pipeline is stalled on a full buffer so the
  // drain can free a slot instead of the load re-reading SRAM every cycle.
  assign store_stall  = bus.store_en & full;
  assign load_act     = bus.load_en & ~store_stall;
  assign load_rd      = load_act & ~hit;
  assign load_blocked = load_rd & ~bus.sram_gnt;
`ifdef DMEM_FWD_EN
  assign load_fwd     = load_act & hit;
  assign fwd_conflict = 1'b0;
`else
  assign fwd_conflict = load_act & hit;
`endif

  assign bus.busy = store_stall | load_blocked | fwd_conflict;

  // Stores are pushed only when the whole request is accepted; otherwise the
  // CPU re-presents it and it would be posted twice.
  assign push = bus.store_en & ~bus.busy;

  // SRAM port: a load read has priority; otherwise the head entry drains.
  assign bus.sram_req   = load_rd | ~empty;
  assign bus.sram_we    = ~load_rd;
  assign bus.sram_addr  = load_rd ? bus.l_addr[W-1:2] : head_addr;
  assign bus.sram_wdata = head_data;
  assign pop            = ~load_rd & ~empty & bus.sram_gnt;

  // Next-state and load-data selection for the load path.
  always_comb begin
    state_d  = DMEM_IDLE;
    l_data_d = l_data_q;
    case (state_q)
      DMEM_RESP: l_data_d = bus.sram_rdata;
      default:   ;
    endcase
    if (load_rd && bus.sram_gnt) state_d = DMEM_RESP;
`ifdef DMEM_FWD_EN
    if (load_fwd) l_data_d = hit_data;
`endif
  end

  // Load FSM state and held load data.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= DMEM_IDLE;
      l_data_q <= '0;
    end else begin
      state_q  <= state_d;
      l_data_q <= l_data_d;
    end
  end

  // SRAM read data arrives in RESP; pass it straight through so both load
  // sources share the same one-cycle latency, and hold it afterwards.
  assign bus.l_data = (state_q == DMEM_RESP) ? bus.sram_rdata : l_data_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: stimulus pushes expected load data and
// expected SRAM writes; a monitor pops and compares when the DUT completes them.
module tb_dmem_responder;
  import dmem_responder_pkg::*;

  localparam int unsigned W = 32;

  logic clk = 1'b0;
  logic rst;

  dmem_responder_if #(.W(W)) bus ();

  dmem_responder #(
    .W        (W),
    .WB_DEPTH (4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [31:0] load_q[$];
  logic [61:0] wr_q[$];
  logic [31:0] last_load = 32'h0;
  logic        pend = 1'b0;
  logic [31:0] mem [1024];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // SRAM model: word array, read data registered on a granted read.
  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 32'hA5A5_0000 | 32'(i);
    mem[10'h040] = 32'hDEAD_BEEF;
    bus.sram_rdata <= '0;
    forever begin
      @(posedge clk);
      if (rst && bus.sram_req && bus.sram_gnt) begin
        if (bus.sram_we) mem[bus.sram_addr[9:0]] = bus.sram_wdata;
        else             bus.sram_rdata <= mem[bus.sram_addr[9:0]];
      end
    end
  end

  // Monitor: completed loads and granted SRAM writes against the scoreboard.
  initial begin
    logic [31:0] exp;
    logic [61:0] wexp;
    forever begin
      @(negedge clk);
      if (pend) begin
        if (load_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL load_unexpected: got 0x%08h expected none", bus.l_data);
        end else begin
          exp = load_q.pop_front();
          check("l_data", bus.l_data, exp);
          last_load = exp;
        end
      end
      pend = rst && bus.load_en && !bus.busy;
      if (rst && bus.sram_req && bus.sram_we && bus.sram_gnt) begin
        if (wr_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL write_unexpected: got addr 0x%08h expected none", {2'b0, bus.sram_addr});
        end else begin
          wexp = wr_q.pop_front();
          check("sram_waddr", {2'b0, bus.sram_addr}, {2'b0, wexp[61:32]});
          check("sram_wdata", bus.sram_wdata, wexp[31:0]);
        end
      end
    end
  end

  task automatic do_store(input logic [31:0] a, input logic [31:0] d, output int stalls);
    bus.store_en = 1'b1;
    bus.s_addr   = a;
    bus.s_data   = d;
    stalls       = 0;
    @(negedge clk);
    while (bus.busy && stalls < 20) begin
      stalls++;
      @(negedge clk);
    end
    if (bus.busy) begin
      n_cmp++;
      n_bad++;
      $display("FAIL store_timeout: got busy 1 expected 0 for addr 0x%08h", a);
    end else begin
      wr_q.push_back({a[31:2], d});
    end
    @(posedge clk);
    #1;
    bus.store_en = 1'b0;
  endtask

  task automatic do_load(input logic [31:0] a, input logic [31:0] exp, output int stalls);
    bus.load_en = 1'b1;
    bus.l_addr  = a;
    stalls      = 0;
    load_q.push_back(exp);
    @(negedge clk);
    while (bus.busy && stalls < 20) begin
      stalls++;
      @(negedge clk);
    end
    if (bus.busy) begin
      n_cmp++;
      n_bad++;
      $display("FAIL load_timeout: got busy 1 expected 0 for addr 0x%08h", a);
    end
    @(posedge clk);
    #1;
    bus.load_en = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int st;
    rst          = 1'b0;
    bus.load_en  = 1'b0;
    bus.store_en = 1'b0;
    bus.l_addr   = '0;
    bus.s_addr   = '0;
    bus.s_data   = '0;
    bus.sram_gnt = 1'b0;
    #2;
    check("rst_l_data", bus.l_data, 32'h0);
    check("rst_busy", {31'b0, bus.busy}, 32'h0);
    check("rst_sram_req", {31'b0, bus.sram_req}, 32'h0);
    #10;
    rst = 1'b1;
    tick();

    // Plain SRAM load.
    bus.sram_gnt = 1'b1;
    do_load(32'h100, 32'hDEAD_BEEF, st);
    check("t1_busy_cycles", 32'(st), 32'h0);
    tick();

    // Two stores to one word, then a load of it.
    bus.sram_gnt = 1'b0;
    do_store(32'h200, 32'h1111_1111, st);
    check("t2_store1_stalls", 32'(st), 32'h0);
    do_store(32'h200, 32'h2222_2222, st);
    check("t2_store2_stalls", 32'(st), 32'h0);
    bus.l_addr  = 32'h200;
    bus.load_en = 1'b1;
    load_q.push_back(32'h2222_2222);
    @(negedge clk);
`ifdef DMEM_FWD_EN
    check("t2_fwd_busy", {31'b0, bus.busy}, 32'h0);
    check("t2_fwd_no_read", {31'b0, bus.sram_we}, 32'h1);
    tick();
    bus.load_en = 1'b0;
`else
    check("t2_conflict_busy", {31'b0, bus.busy}, 32'h1);
    check("t2_conflict_no_read", {31'b0, bus.sram_we}, 32'h1);
    tick();
    bus.sram_gnt = 1'b1;
    st = 0;
    @(negedge clk);
    while (bus.busy && st < 10) begin
      st++;
      @(negedge clk);
    end
    check("t2_conflict_drain_cycles", 32'(st), 32'h2);
    tick();
    bus.load_en = 1'b0;
`endif
    bus.sram_gnt = 1'b1;
    repeat (3) tick();

    // Fill the buffer, fifth store waits for a pop plus one cycle.
    bus.sram_gnt = 1'b0;
    for (int i = 0; i < 4; i++) begin
      do_store(32'h10 + 32'(4 * i), 32'hA000_0001 + 32'(i), st);
      check("t3_fill_stalls", 32'(st), 32'h0);
    end
    bus.store_en = 1'b1;
    bus.s_addr   = 32'h20;
    bus.s_data   = 32'hA000_0005;
    @(negedge clk);
    check("t3_full_busy", {31'b0, bus.busy}, 32'h1);
    tick();
    bus.sram_gnt = 1'b1;
    @(negedge clk);
    check("t3_pop_cycle_busy", {31'b0, bus.busy}, 32'h1);
    tick();
    @(negedge clk);
    check("t3_after_pop_busy", {31'b0, bus.busy}, 32'h0);
    wr_q.push_back({30'h8, 32'hA000_0005});
    tick();
    bus.store_en = 1'b0;
    repeat (5) tick();

    // Ungranted load miss for three cycles.
    bus.sram_gnt = 1'b0;
    bus.l_addr   = 32'h104;
    bus.load_en  = 1'b1;
    load_q.push_back(32'hA5A5_0041);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("t4_stall_busy", {31'b0, bus.busy}, 32'h1);
      check("t4_l_data_held", bus.l_data, last_load);
      tick();
    end
    bus.sram_gnt = 1'b1;
    @(negedge clk);
    check("t4_granted_busy", {31'b0, bus.busy}, 32'h0);
    tick();
    bus.load_en = 1'b0;

    // Load miss takes the port from a pending drain.
    bus.sram_gnt = 1'b0;
    do_store(32'h400, 32'hC000_0001, st);
    do_store(32'h404, 32'hC000_0002, st);
    do_store(32'h408, 32'hC000_0003, st);
    bus.sram_gnt = 1'b1;
    bus.l_addr   = 32'h10C;
    bus.load_en  = 1'b1;
    load_q.push_back(32'hA5A5_0043);
    @(negedge clk);
    check("t5_load_wins_we", {31'b0, bus.sram_we}, 32'h0);
    check("t5_load_addr", {2'b0, bus.sram_addr}, 32'h43);
    check("t5_load_busy", {31'b0, bus.busy}, 32'h0);
    tick();
    bus.load_en = 1'b0;
    @(negedge clk);
    check("t5_drain_resume_we", {31'b0, bus.sram_we}, 32'h1);
    check("t5_drain_addr", {2'b0, bus.sram_addr}, 32'h100);
    tick();
    tick();
    tick();
    @(negedge clk);
    check("t5_empty_req", {31'b0, bus.sram_req}, 32'h0);
    do_load(32'h404, 32'hC000_0002, st);
    check("t5_readback_stalls", 32'(st), 32'h0);
    tick();

    // Reset while two entries are still waiting to drain.
    bus.sram_gnt = 1'b0;
    do_store(32'h300, 32'hD000_0001, st);
    do_store(32'h304, 32'hD000_0002, st);
    do_store(32'h308, 32'hD000_0003, st);
    bus.sram_gnt = 1'b1;
    tick();
    #2;
    rst = 1'b0;
    #1;
    check("t6_rst_l_data", bus.l_data, 32'h0);
    check("t6_rst_busy", {31'b0, bus.busy}, 32'h0);
    check("t6_rst_sram_req", {31'b0, bus.sram_req}, 32'h0);
    wr_q.delete();
    @(negedge clk);
    #1;
    rst = 1'b1;
    tick();
    do_load(32'h304, 32'hA5A5_00C1, st);
    check("t6_load_after_rst_stalls", 32'(st), 32'h0);
    do_load(32'h300, 32'hD000_0001, st);
    tick();
    tick();

    check("end_load_q_empty", 32'(load_q.size()), 32'h0);
    check("end_wr_q_empty", 32'(wr_q.size()), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
